imm_extend_stage: RTL
=====================

# imm_extend_stage

Registered, parametrised immediate generator for the decode/execute boundary of the pipelined core. It decodes the immediate of every RV32I/RV64I instruction format to `DATA_WIDTH` bits and computes the PC-relative target `pc + imm` in the same stage. Results are held behind a valid/ready handshake with a two-entry skid, so execute back-pressure never drops or duplicates an instruction. The block supports pipeline flush.

## Interface
- `DATA_WIDTH`, 32: datapath/XLEN width; legal values 32 or 64.
- `INSTR_WIDTH`, 32: instruction width; fixed at 32.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `flush_i` input 1: discards all held entries.
- `valid_i` input 1: upstream presents an instruction.
- `ready_o` output 1: block can accept an instruction.
- `instr_i` input INSTR_WIDTH: instruction word.
- `imm_src_i` input 3: format select.
- `pc_i` input DATA_WIDTH: PC of `instr_i`.
- `valid_o` output 1: result valid.
- `ready_i` input 1: downstream accepts the result.
- `imm_ext_o` output DATA_WIDTH: extended immediate.
- `target_o` output DATA_WIDTH: `pc + imm_ext`.
- `pc_o` output DATA_WIDTH: PC carried through with the result.
- `illegal_o` output 1: `imm_src` was reserved (111).

## Operation
- **Formats** (S = `instr[31]` replicated to `DATA_WIDTH`):
  - 000 I: S, `instr[31:20]`.
  - 001 S: S, `instr[31:25]`, `instr[11:7]`.
  - 010 B: S, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0.
  - 011 J: S, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0.
  - 100 U: S, `instr[31:12]`, 12'b0. At 64 bits, bit 31 is sign-extended.
  - 101 Z (CSR uimm): zero-extended `instr[19:15]`.
  - 110 shamt: zero-extended `instr[24:20]` at `DATA_WIDTH` 32; `instr[25:20]` at 64.
  - 111: `imm` = 0, `target` = `pc`, `illegal` = 1.
- **Target:** `target = pc_i + imm_ext`, computed modulo 2^`DATA_WIDTH`. No overflow flag; wrap-around is silent.
- **Decode timing:** decode and add are combinational on the input side. The decoded payload `{imm, target, pc, illegal}` is stored at acceptance.
- **Storage:** output register OUT (`valid_o` = `out_v`) plus one skid register SKID (`skid_v`).
  - States by `{out_v, skid_v}`: EMPTY 00, ONE 10, FULL 11. State 01 is unreachable.
- **Handshake rules:**
  - `ready_o = !skid_v`.
  - Accept = `valid_i & ready_o`.
  - Fire = `valid_o & ready_i`.
- **Each cycle, when not flushed:**
  - OUT free (`!out_v` or fire):
    - If `skid_v`: OUT loads SKID, and `skid_v` clears.
    - Else if accept: OUT loads the input.
    - Else: `out_v` clears.
  - OUT stalled (`out_v & !ready_i`) and accept: SKID loads the input, and `skid_v` sets.
- **Transitions:**
  - EMPTY→ONE on accept.
  - ONE→FULL on accept while stalled.
  - ONE→EMPTY on fire without accept.
  - FULL→ONE on fire.
- **Ordering:** strictly FIFO; an entry in SKID always leaves before any newer one.
- **Flush:** `flush_i` clears `out_v` and `skid_v` at the next edge. An input offered in the flush cycle is dropped even if `ready_o` = 1. Flush has priority over accept and fire; the downstream must ignore a fire in the flush cycle.
- **Reset:** `rst` has priority over flush and behaves identically to it. It also zeroes all payload registers.

## Timing
- **Latency:** accept at edge N gives `valid_o` from cycle N+1, when the block was EMPTY or firing.
- **Throughput:** one instruction per cycle while `ready_i` is held high.
- **After a stall:**
  - `ready_o` falls the cycle after a stalled accept (FULL).
  - `ready_o` rises the cycle after the first fire from FULL.
- **Output stability:** outputs are registered. While `valid_o` = 1 and `ready_i` = 0, all of `imm_ext_o`, `target_o`, `pc_o` and `illegal_o` hold stable.
- **`ready_o` path:** `ready_o` is a function of state only; it has no combinational path from `ready_i`.
- **Reset values:**
  - `valid_o` = 0 and `illegal_o` = 0.
  - `imm_ext_o`, `target_o` and `pc_o` = 0.
  - `ready_o` = 1 from the first cycle after reset.

## Test plan
- **I-type at 32 bits:** `instr` 0xFFF00093, src 000, `pc` 0x1000. Require `imm` 0xFFFFFFFF and `target` 0x00000FFF, with `valid_o` one cycle after accept.
- **B-type and J-type:**
  - 0xFE000EE3, src 010, `pc` 0x100 → `imm` 0xFFFFFFFC, `target` 0xFC.
  - 0x0010006F, src 011, `pc` 0x0 → `imm` 0x800.
- **U-type at 64 bits:** `DATA_WIDTH` 64, 0x800000B7, src 100, `pc` 0x10 → `imm` 0xFFFFFFFF80000000, `target` 0xFFFFFFFF80000010.
- **Back-pressure:** A, B, C offered back-to-back with `ready_i` = 0 for 3 cycles.
  - A sits in OUT and B in SKID; `ready_o` = 0 and C is held.
  - Then `ready_i` = 1 → outputs A, B, C in consecutive cycles with no loss or duplication.
- **Flush and reset in FULL:**
  - Assert `flush_i` with a new input valid → next cycle `valid_o` = 0, `ready_o` = 1, and the new input is not emitted.
  - Repeat with `rst`; additionally all payload outputs = 0.
- **Reserved and wrap:**
  - src 111 → `imm` 0, `target` = `pc`, `illegal_o` = 1.
  - `pc` 0xFFFFFFFC with I-imm +8 → `target` 0x00000004.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate generator and PC-relative target adder for the decode/execute
// boundary. Results sit behind a valid/ready handshake with a two-entry skid
// (OUT + SKID), so execute back-pressure never drops or duplicates an entry.
module imm_extend_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [2:0]             imm_src_i,
  input  logic [DATA_WIDTH-1:0]  pc_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_WIDTH-1:0]  imm_ext_o,
  output logic [DATA_WIDTH-1:0]  target_o,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic                   illegal_o
);

  typedef enum logic [2:0] {
    FMT_I     = 3'b000,
    FMT_S     = 3'b001,
    FMT_B     = 3'b010,
    FMT_J     = 3'b011,
    FMT_U     = 3'b100,
    FMT_Z     = 3'b101,
    FMT_SHAMT = 3'b110,
    FMT_RSVD  = 3'b111
  } fmt_t;

  // Encoded as {out_v, skid_v}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_FULL  = 2'b11
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] pc;
    logic                  illegal;
  } payload_t;

  logic [31:0] raw;
  logic        sext;
  logic        ill;
  logic [DATA_WIDTH-1:0] imm_in;
  payload_t    in_pl;
  payload_t    out_q;
  payload_t    skid_q;
  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        load_out;
  logic        out_from_skid;
  logic        load_skid;
  logic        unused_opcode;

  assign unused_opcode = ^instr_i[6:0];

  // Decode the immediate into a 32-bit field, then extend to DATA_WIDTH.
  always_comb begin
    raw  = '0;
    sext = 1'b1;
    ill  = 1'b0;
    case (fmt_t'(imm_src_i))
      FMT_I:     raw = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:     raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:     raw = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_J:     raw = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      FMT_U:     raw = {instr_i[31:12], 12'b0};
      FMT_Z: begin
        sext = 1'b0;
        raw  = {27'b0, instr_i[19:15]};
      end
      FMT_SHAMT: begin
        sext = 1'b0;
        raw  = {26'b0, (DATA_WIDTH == 64) & instr_i[25], instr_i[24:20]};
      end
      default: begin
        raw = '0;
        ill = 1'b1;
      end
    endcase
  end

  assign imm_in        = sext ? DATA_WIDTH'($signed(raw)) : DATA_WIDTH'(raw);
  assign in_pl.imm     = imm_in;
  assign in_pl.target  = pc_i + imm_in;
  assign in_pl.pc      = pc_i;
  assign in_pl.illegal = ill;

  assign ready_o = (state != S_FULL);
  assign valid_o = (state != S_EMPTY);
  assign accept  = valid_i & ready_o;

  // Occupancy state register; reset outranks flush.
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  // Next state and OUT/SKID load controls; flush overrides accept and fire.
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    out_from_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush_i) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            load_out  = 1'b1;
            state_nxt = S_ONE;
          end
        end
        S_ONE: begin
          if (ready_i) begin
            load_out  = accept;
            state_nxt = accept ? S_ONE : S_EMPTY;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = S_FULL;
          end
        end
        S_FULL: begin
          if (ready_i) begin
            load_out      = 1'b1;
            out_from_skid = 1'b1;
            state_nxt     = S_ONE;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // Payload registers; the older SKID entry always moves to OUT first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : in_pl;
      if (load_skid) skid_q <= in_pl;
    end
  end

  assign imm_ext_o = out_q.imm;
  assign target_o  = out_q.target;
  assign pc_o      = out_q.pc;
  assign illegal_o = out_q.illegal;

endmodule
